// File: rtl/vx_dp_ram_clr.sv
// Simple dual-port RAM (one write, one read port) with per-lane write enables,
// registered read path, optional output stage and a post-reset clear sequencer.
module vx_dp_ram_clr #(
  parameter int               DATAW      = 32,
  parameter int               SIZE       = 64,
  parameter int               WRENW      = 4,
  parameter int               OUT_REG    = 0,
  parameter int               RW_MODE    = 0,
  parameter int               RESET_RAM  = 1,
  parameter logic [DATAW-1:0] INIT_VALUE = '0,
  parameter int               ADDRW      = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             write,
  input  logic [ADDRW-1:0] waddr,
  input  logic [WRENW-1:0] wren,
  input  logic [DATAW-1:0] wdata,
  input  logic             read,
  input  logic [ADDRW-1:0] raddr,
  output logic             rvalid,
  output logic [DATAW-1:0] rdata
);

  localparam int               LW        = DATAW / WRENW;
  localparam logic [ADDRW:0]   SIZE_W    = (ADDRW + 1)'(SIZE);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  if (!(WRENW == 1 || (DATAW % WRENW) == 0)) begin : g_bad_wrenw
    $error("vx_dp_ram_clr: DATAW must be a multiple of WRENW");
  end
  if (!(RW_MODE == 0 || RW_MODE == 1)) begin : g_bad_rw_mode
    $error("vx_dp_ram_clr: RW_MODE must be 0 or 1");
  end
  if (SIZE < 2) begin : g_bad_size
    $error("vx_dp_ram_clr: SIZE must be at least 2");
  end

  logic [DATAW-1:0] mem_q [SIZE];

  logic [1:0]       state_q, state_d;
  logic [ADDRW-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;
  logic             clr_we_s;

  logic             wr_in_range_s, rd_in_range_s;
  logic             user_we_s, rd_fire_s;
  logic [ADDRW-1:0] rd_idx_s;
  logic [DATAW-1:0] rd_old_s, rd_merged_s, rd_word_s;

  logic             rvalid1_q;
  logic [DATAW-1:0] rdata1_q;

  // The first reset-free cycle (still in RST) already clears word 0, so the
  // whole array is filled in exactly SIZE cycles.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_s  = 1'b0;
    case (state_q)
      ST_RST: begin
        if (RESET_RAM != 0) begin
          clr_we_s  = 1'b1;
          clr_cnt_d = clr_cnt_q + ADDRW'(1);
          state_d   = ST_CLEAR;
        end else begin
          state_d   = ST_RUN;
        end
      end
      ST_CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDRW'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_RST;
        clr_cnt_d = '0;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Sequencer state, clear counter and ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RST;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // User-port qualification; out-of-range addresses never touch the array.
  always_comb begin
    wr_in_range_s = ({1'b0, waddr} < SIZE_W);
    rd_in_range_s = ({1'b0, raddr} < SIZE_W);
    user_we_s     = ready_q & write & ~reset & wr_in_range_s;
    rd_fire_s     = ready_q & read & ~reset;
    rd_idx_s      = rd_in_range_s ? raddr : '0;
  end

  // Read word selection, including the same-address bypass for RW_MODE=1.
  always_comb begin
    rd_old_s    = mem_q[rd_idx_s];
    rd_merged_s = rd_old_s;
    for (int i = 0; i < WRENW; i++) begin
      rd_merged_s[i*LW +: LW] = wren[i] ? wdata[i*LW +: LW] : rd_old_s[i*LW +: LW];
    end
    if (!rd_in_range_s) begin
      rd_word_s = '0;
    end else if ((RW_MODE != 0) && user_we_s && (waddr == raddr)) begin
      rd_word_s = rd_merged_s;
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  // Storage array: clear writes and lane-masked user writes.
  always_ff @(posedge clk) begin
    if (clr_we_s && !reset) begin
      mem_q[clr_cnt_q] <= INIT_VALUE;
    end else if (user_we_s) begin
      for (int i = 0; i < WRENW; i++) begin
        if (wren[i]) begin
          mem_q[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
        end
      end
    end
  end

  // First read stage; data holds when no read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid1_q <= 1'b0;
      rdata1_q  <= '0;
    end else begin
      rvalid1_q <= rd_fire_s;
      if (rd_fire_s) begin
        rdata1_q <= rd_word_s;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             rvalid2_q;
    logic [DATAW-1:0] rdata2_q;

    // Second output stage, fully pipelined behind the first.
    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else begin
        rvalid2_q <= rvalid1_q;
        if (rvalid1_q) begin
          rdata2_q <= rdata1_q;
        end
      end
    end

    assign rvalid = rvalid2_q;
    assign rdata  = rdata2_q;
  end else begin : g_no_out_reg
    assign rvalid = rvalid1_q;
    assign rdata  = rdata1_q;
  end

  assign ready = ready_q;

endmodule
